tile_renderer: RTL and testbench
================================

Name: tile_renderer

Overview:
- Pixel stage directly downstream of the sync generator.
- Consumes its xPos/yPos/isActive/hSync/vSync and fetches 8x8 tile data from a synchronous VRAM read port.
- Produces a registered 4-bit colour index per clock, plus sync/active delayed to match.
- Active area is 256x192 (32x24 tiles). Each tile has a name byte, 8 pattern bytes and one colour byte (fg = [7:4], bg = [3:0]).

Parameters:
- NAME_BASE, 14'h1800, VRAM base of the 32x24 name table (768 bytes, row-major).
- PATTERN_BASE, 14'h0000, VRAM base of the pattern table (256 tiles x 8 bytes; byte = tile row, bit 7 = leftmost pixel).
- COLOR_BASE, 14'h2000, VRAM base of the per-tile colour table (768 bytes, same indexing as the name table).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- xPos  in  9  signed pixel column from the sync generator
- yPos  in  9  signed pixel line from the sync generator
- isActive  in  1  active-region flag from the sync generator
- hSync  in  1  horizontal sync from the sync generator
- vSync  in  1  vertical sync from the sync generator
- vramAddr  out  14  VRAM read address (registered)
- vramRead  out  1  read strobe; data valid on vramData one cycle later
- vramData  in  8  VRAM read data
- colorIdx  out  4  pixel colour index (registered)
- hSyncOut  out  1  hSync delayed 1 cycle
- vSyncOut  out  1  vSync delayed 1 cycle
- activeOut  out  1  isActive delayed 1 cycle

Behaviour:
- Reset (reset low, async): vramAddr=0, vramRead=0, colorIdx=0, hSyncOut=0, vSyncOut=0, activeOut=0; shifter, nextPattern, nextColor, curColor, latchedName all cleared.
- Fetch window: yPos in 0..191 AND fx = xPos+8 (9-bit) in 0..255, i.e. xPos in -8..247.
  - Lookahead tile: col = fx[7:3], row = yPos[7:3], tIdx = row*32 + col. Phase p = xPos[2:0].
- Fetch sequence, per edge, inside the window:
  - p==0: vramAddr <= NAME_BASE + tIdx; vramRead <= 1.
  - p==1: latchedName <= vramData; vramAddr <= PATTERN_BASE + {vramData,3'b0} + yPos[2:0]; vramRead <= 1.
  - p==2: nextPattern <= vramData; vramAddr <= COLOR_BASE + tIdx; vramRead <= 1.
  - p==3: nextColor <= vramData; vramRead <= 0.
  - p==4..6: idle, vramRead <= 0.
  - p==7: shifter <= nextPattern; curColor <= nextColor.
  - Otherwise: shifter <= shifter << 1.
- Outside the window: vramRead <= 0. vramAddr holds. The shifter still shifts, filling with zeros.
- The FSM is implicit in p. It is stateless across lines, so any xPos discontinuity (hShift change) realigns within 8 cycles. Garbage is allowed for at most one tile.
- Pixel output, every edge:
  - colorIdx <= isActive ? (shifter[7] ? curColor[7:4] : curColor[3:0]) : 4'h0.
  - hSyncOut <= hSync; vSyncOut <= vSync; activeOut <= isActive.
- Latency: the pixel for input (xPos, yPos) appears on colorIdx exactly 1 cycle later, aligned with the delayed sync/active signals.
- Address arithmetic is 14-bit and wraps modulo 2^14. tIdx max = 767.
- Line/frame wrap needs no special handling. The tile 0 prefetch at xPos=-8..-1 of each active line loads the pixel 0 data.
- Reset mid-line: outputs are 0 until the next p==7 load inside the window.

Optional Feature:
- Macro: TILE_RENDERER_BORDER_EN.
- With the macro: add input borderColor[3:0]. When isActive==0 and hSync==0 and vSync==0, colorIdx <= borderColor; during sync it stays 0.
- Without the macro: no port, and colorIdx is 0 whenever isActive==0.

Test Plan:
1. Reset low for 3 cycles mid-line, then release -> all outputs 0 during reset; colorIdx 0 until the first p==7 load.
2. VRAM name[0]=8'h41, pattern[0x41*8+0]=8'hA5, color[0]=8'hF1; sweep line 0 from xPos=-8 -> at p==0 vramAddr=14'h1800, at p==1 vramAddr=14'h0208, at p==2 vramAddr=14'h2000; colorIdx for x=0..7 (1 cycle later) = F,1,F,1,1,F,1,F.
3. yPos=191, xPos=247, name[767]=8'h02, pattern[0x02*8+7]=8'h80 -> vramAddr 14'h1AFF then 14'h0017; at xPos=248 no vramRead; pixel 255 shows bg of color[767].
4. yPos=192 (inactive) and yPos=-1 -> vramRead stays 0 for the entire line; colorIdx=0.
5. Toggle hSync/vSync/isActive -> hSyncOut/vSyncOut/activeOut reproduce each edge exactly 1 cycle later.
6. With TILE_RENDERER_BORDER_EN and borderColor=4'h7 -> colorIdx=7 at xPos=-3 (non-sync, inactive), 0 during hSync, tile data at xPos 0..255.

Source files
------------

// File: rtl/tile_renderer_if.sv
// VRAM read bus between tile_renderer (master) and a synchronous VRAM read port (slave).
// Address and strobe are registered by the master; data answers the presented address.
interface tile_renderer_if;
  logic [13:0] vramAddr;
  logic        vramRead;
  logic [7:0]  vramData;

  modport master (output vramAddr, vramRead, input vramData);
  modport slave  (input vramAddr, vramRead, output vramData);
endinterface

// File: rtl/tile_renderer.sv
// Tile pixel stage: fetches name/pattern/colour one 8x8 tile ahead and shifts out a 4-bit colour index.
// Optional macro TILE_RENDERER_BORDER_EN adds borderColor for the inactive, non-sync region.
module tile_renderer #(
  parameter logic [13:0] NAME_BASE    = 14'h1800,
  parameter logic [13:0] PATTERN_BASE = 14'h0000,
  parameter logic [13:0] COLOR_BASE   = 14'h2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [8:0] xPos,
  input  logic signed [8:0] yPos,
  input  logic              isActive,
  input  logic              hSync,
  input  logic              vSync,
`ifdef TILE_RENDERER_BORDER_EN
  input  logic [3:0]        borderColor,
`endif
  tile_renderer_if.master   vram,
  output logic [3:0]        colorIdx,
  output logic              hSyncOut,
  output logic              vSyncOut,
  output logic              activeOut
);
  logic [5:0] fx_hi;
  logic       in_win;
  logic [2:0] phase;
  logic [9:0] tile_idx;
  logic [7:0] name_byte, shifter, next_pattern, next_color, cur_color, latched_name;
  logic [3:0] pix;

  // Lookahead column is (xPos+8)>>3; the +8 only touches bits 3 and up.
  assign fx_hi     = xPos[8:3] + 6'd1;
  assign in_win    = !yPos[8] && (yPos[7:6] != 2'b11) && !fx_hi[5];
  assign phase     = xPos[2:0];
  assign tile_idx  = {yPos[7:3], fx_hi[4:0]};
  assign name_byte = (phase == 3'd1) ? vram.vramData : latched_name;
  assign pix       = shifter[7] ? cur_color[7:4] : cur_color[3:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vram.vramAddr <= '0;
      vram.vramRead <= 1'b0;
      shifter       <= '0;
      next_pattern  <= '0;
      next_color    <= '0;
      cur_color     <= '0;
      latched_name  <= '0;
    end else begin
      vram.vramRead <= 1'b0;
      shifter       <= {shifter[6:0], 1'b0};
      if (in_win) begin
        case (phase)
          3'd0: begin
            vram.vramAddr <= NAME_BASE + {4'd0, tile_idx};
            vram.vramRead <= 1'b1;
          end
          3'd1: begin
            latched_name  <= vram.vramData;
            vram.vramAddr <= PATTERN_BASE + {3'd0, name_byte, 3'd0} + {11'd0, yPos[2:0]};
            vram.vramRead <= 1'b1;
          end
          3'd2: begin
            next_pattern  <= vram.vramData;
            vram.vramAddr <= COLOR_BASE + {4'd0, tile_idx};
            vram.vramRead <= 1'b1;
          end
          3'd3: next_color <= vram.vramData;
          3'd7: begin
            shifter   <= next_pattern;
            cur_color <= next_color;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      colorIdx  <= 4'h0;
      hSyncOut  <= 1'b0;
      vSyncOut  <= 1'b0;
      activeOut <= 1'b0;
    end else begin
      if (isActive)
        colorIdx <= pix;
`ifdef TILE_RENDERER_BORDER_EN
      else if (!hSync && !vSync)
        colorIdx <= borderColor;
`endif
      else
        colorIdx <= 4'h0;
      hSyncOut  <= hSync;
      vSyncOut  <= vSync;
      activeOut <= isActive;
    end
  end
endmodule

// File: tb/tb_tile_renderer.sv
// Directed line sweeps against a VRAM image; expected outputs are queued per drive and checked after the edge.
module tb_tile_renderer;
  localparam logic [13:0] NAME_BASE = 14'h1800;
  localparam logic [13:0] PAT_BASE  = 14'h0000;
  localparam logic [13:0] COL_BASE  = 14'h2000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic signed [8:0] xPos = '0;
  logic signed [8:0] yPos = '0;
  logic              isActive = 1'b0, hSync = 1'b0, vSync = 1'b0;
  logic [3:0]        borderColor = 4'h7;
  logic [3:0]        colorIdx;
  logic              hSyncOut, vSyncOut, activeOut;

  always #5 clk = ~clk;

  tile_renderer_if vram ();
  logic [7:0] mem [0:16383];
  assign vram.vramData = mem[vram.vramAddr];

  tile_renderer dut (
    .clk(clk), .reset(reset), .xPos(xPos), .yPos(yPos),
    .isActive(isActive), .hSync(hSync), .vSync(vSync),
`ifdef TILE_RENDERER_BORDER_EN
    .borderColor(borderColor),
`endif
    .vram(vram), .colorIdx(colorIdx),
    .hSyncOut(hSyncOut), .vSyncOut(vSyncOut), .activeOut(activeOut)
  );

  typedef struct packed {
    logic [13:0] addr;
    logic        rd;
    logic [3:0]  col;
    logic        col_chk;
    logic        hs, vs, act;
  } exp_t;

  exp_t        q[$];
  int          errors = 0, checks = 0;
  int          cur_x, cur_y;
  logic [13:0] exp_addr = '0;
  bit          loaded = 0, seen_p0 = 0, known = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s x=%0d y=%0d got=%0h want=%0h", tag, cur_x, cur_y, got, want);
    end
  endtask

  // Reference pixel straight from the VRAM image.
  function automatic logic [3:0] model_pix(input int x, input int y);
    logic [13:0] ti;
    logic [7:0]  nm, pat, cl;
    ti  = 14'((y / 8) * 32 + x / 8);
    nm  = mem[NAME_BASE + ti];
    pat = mem[PAT_BASE + {3'b0, nm, 3'b0} + 14'(y % 8)];
    cl  = mem[COL_BASE + ti];
    return pat[7 - (x % 8)] ? cl[7:4] : cl[3:0];
  endfunction

  task automatic tick(input int x, input int y, input bit act, input bit hs, input bit vs);
    exp_t        e, g;
    bit          inwin;
    int          p;
    logic [13:0] ti;
    xPos = 9'(x); yPos = 9'(y); isActive = act; hSync = hs; vSync = vs;
    e = '0;
    if (!reset) begin
      e.col_chk = 1'b1;
      exp_addr = '0; loaded = 0; seen_p0 = 0; known = 0;
    end else begin
      e.hs = hs; e.vs = vs; e.act = act;
      inwin = (y >= 0) && (y < 192) && (x >= -8) && (x < 248);
      p  = x & 7;
      ti = inwin ? 14'((y / 8) * 32 + (x + 8) / 8) : 14'd0;
      if (inwin) begin
        case (p)
          0: begin exp_addr = NAME_BASE + ti; e.rd = 1'b1; seen_p0 = 1; end
          1: begin exp_addr = PAT_BASE + {3'b0, mem[exp_addr], 3'b0} + 14'(y % 8); e.rd = 1'b1; end
          2: begin exp_addr = COL_BASE + ti; e.rd = 1'b1; end
          default: ;
        endcase
      end
      e.addr = exp_addr;
      if (act) begin
        if (!loaded) begin e.col = 4'h0; e.col_chk = 1'b1; end
        else if (known) begin e.col = model_pix(x, y); e.col_chk = 1'b1; end
      end else begin
        e.col_chk = 1'b1;
`ifdef TILE_RENDERER_BORDER_EN
        e.col = (!hs && !vs) ? borderColor : 4'h0;
`endif
      end
      if (inwin && p == 7) begin loaded = 1; known = seen_p0; end
    end
    q.push_back(e);
    @(posedge clk); #1;
    cur_x = x; cur_y = y;
    g = q.pop_front();
    chk("vramAddr", 16'(vram.vramAddr), 16'(g.addr));
    chk("vramRead", 16'(vram.vramRead), 16'(g.rd));
    chk("hSyncOut", 16'(hSyncOut), 16'(g.hs));
    chk("vSyncOut", 16'(vSyncOut), 16'(g.vs));
    chk("activeOut", 16'(activeOut), 16'(g.act));
    if (g.col_chk) chk("colorIdx", 16'(colorIdx), 16'(g.col));
  endtask

  task automatic line(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++)
      tick(x, y, (x >= 0 && x < 256 && y >= 0 && y < 192), (x < -18), (y == -2));
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[14'h1800] = 8'h41;
    mem[14'h0208] = 8'hA5;
    mem[14'h2000] = 8'hF1;
    mem[14'h1AFF] = 8'h02;
    mem[14'h0017] = 8'h80;

    reset = 1'b0;
    line(3, 40, 43);
    reset = 1'b1;
    line(0, -24, 255);
    line(1, -24, 255);
    line(190, -24, 255);
    line(191, -24, 255);
    line(192, -24, 255);
    line(-2, -24, 255);
    line(-1, -24, 255);
    line(5, -24, 100);
    reset = 1'b0;
    line(5, 101, 103);
    reset = 1'b1;
    line(5, 104, 255);
    line(6, -24, 255);
    line(100, -24, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
